// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: oversampled start detection, mid-bit sampling,
// and a one-byte holding register with ready / framing-error / overrun status.
module uart_rx_deframer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_ferr,
  output logic       rx_ovr,
  output logic       rx_busy,
  output logic [2:0] dbg_state
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    sh;
  logic          rx_m;
  logic          rx_s;
  logic          stop_tick;
  logic          accept;

  // Host handshake: rx_ready is the valid for rx_data; a one-cycle rd_en is
  // the acknowledge. A byte finishing in the same cycle as rd_en replaces the
  // acknowledged one, so rx_ready stays high across that edge.
  assign stop_tick = baud_tick && (state == S_STOP) && (tcnt == T_END);
  assign accept    = !rx_ready || rd_en;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      bcnt     <= '0;
      sh       <= '0;
      rx_data  <= '0;
      rx_ready <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_busy  <= 1'b0;
    end else if (clr) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      bcnt     <= '0;
      rx_ready <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      if (stop_tick) begin
        if (accept) begin
          rx_data  <= sh;
          rx_ready <= 1'b1;
          rx_ferr  <= ~rx_s;
          rx_ovr   <= 1'b0;
        end else begin
          rx_ovr <= 1'b1;
        end
      end else if (rd_en) begin
        rx_ready <= 1'b0;
        rx_ferr  <= 1'b0;
        rx_ovr   <= 1'b0;
      end

      if (baud_tick) begin
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              state   <= S_START;
              tcnt    <= '0;
              rx_busy <= 1'b1;
            end
          end
          S_START: begin
            if (tcnt == T_MID) begin
              tcnt <= '0;
              if (rx_s) begin
                state   <= S_IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= S_DATA;
                bcnt  <= '0;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          S_DATA: begin
            if (tcnt == T_END) begin
              tcnt <= '0;
              sh   <= {rx_s, sh[7:1]};
              if (bcnt == 3'd7) begin
                state <= S_STOP;
                bcnt  <= '0;
              end else begin
                bcnt <= bcnt + 3'd1;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          S_STOP: begin
            if (tcnt == T_END) begin
              tcnt <= '0;
              // A low stop bit parks in BREAK so a held-low line cannot re-trigger.
              if (rx_s) begin
                state   <= S_IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= S_BREAK;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          S_BREAK: begin
            if (rx_s) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= S_IDLE;
            tcnt    <= '0;
            bcnt    <= '0;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: tick-aligned line waveforms, a frame-level
// reference model checked every cycle, directed scenarios plus random traffic.
module tb_uart_rx_deframer;

  localparam int OS       = 16;
  localparam int HALF     = OS / 2;
  localparam int STOP_OFS = HALF + 9 * OS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       baud_tick;
  logic       rx;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ferr;
  logic       rx_ovr;
  logic       rx_busy;
  logic [2:0] dbg_state;

  uart_rx_deframer #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rd_en     (rd_en),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rx_ferr   (rx_ferr),
    .rx_ovr    (rx_ovr),
    .rx_busy   (rx_busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, m_k);
    end
  endtask

  // reference model: frame timing derived from the detection tick by offsets
  int         m_mode;   // 0 idle, 1 in frame, 2 break
  int         m_d;
  int         m_k = 0;
  bit         hist [0:65535];
  logic [7:0] m_data;
  bit         m_ready;
  bit         m_ferr;
  bit         m_ovr;
  logic [7:0] exp_q [$];

  task automatic model_reset();
    m_mode  = 0;
    m_d     = 0;
    m_data  = 8'h00;
    m_ready = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit c);
    bit         done;
    bit         stop_b;
    logic [7:0] b;
    done   = 1'b0;
    stop_b = 1'b0;
    b      = 8'h00;
    hist[m_k] = l;
    if (c) begin
      m_mode  = 0;
      m_ready = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (m_mode == 0) begin
        if (!l) begin
          m_mode = 1;
          m_d    = m_k;
        end
      end else if (m_mode == 1) begin
        if (m_k == m_d + HALF && l) begin
          m_mode = 0;
        end else if (m_k == m_d + STOP_OFS) begin
          for (int i = 0; i < 8; i++) b[i] = hist[m_d + HALF + OS * (i + 1)];
          stop_b = l;
          done   = 1'b1;
          m_mode = l ? 0 : 2;
        end
      end else begin
        if (l) m_mode = 0;
      end
      if (done) begin
        if (!m_ready || r) begin
          m_data  = b;
          m_ready = 1'b1;
          m_ferr  = !stop_b;
          m_ovr   = 1'b0;
          exp_q.push_back(b);
        end else begin
          m_ovr = 1'b1;
        end
      end else if (r) begin
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
      end
    end
    m_k++;
  endtask

  // scoreboard: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en)
      check("cycle_outputs",
            {18'd0, rx_data, rx_ready, rx_ferr, rx_ovr, rx_busy, dbg_state != 3'd0},
            {18'd0, m_data, m_ready, m_ferr, m_ovr, m_mode != 0, m_mode != 0});
  end

  // driver: one entry per baud tick; rx settles through the synchronizer
  // before the tick edge, so the DUT samples entry k on tick k
  bit line_q [$];
  bit rd_q   [$];
  bit clr_q  [$];

  task automatic push(input bit l, input int n);
    repeat (n) begin
      line_q.push_back(l);
      rd_q.push_back(1'b0);
      clr_q.push_back(1'b0);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input bit stop_b);
    push(1'b0, OS);
    for (int i = 0; i < 8; i++) push(b[i], OS);
    push(stop_b, OS);
  endtask

  function automatic int next_idx();
    return m_k + line_q.size();
  endfunction

  task automatic set_rd(input int idx);
    rd_q[idx - m_k] = 1'b1;
  endtask

  task automatic set_clr(input int idx);
    clr_q[idx - m_k] = 1'b1;
  endtask

  task automatic do_tick(input bit l, input bit r, input bit c);
    @(negedge clk);
    rx = l; baud_tick = 1'b0; rd_en = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    baud_tick = 1'b1; rd_en = r; clr = c;
    @(posedge clk);
    model_step(l, r, c);
    #1;
  endtask

  task automatic play_to(input int idx);
    bit l, r, c;
    while (m_k <= idx) begin
      if (line_q.size() == 0) push(1'b1, 1);
      l = line_q.pop_front();
      r = rd_q.pop_front();
      c = clr_q.pop_front();
      do_tick(l, r, c);
    end
  endtask

  task automatic play_all();
    play_to(next_idx() - 1);
  endtask

  int         s, s2, g, kind, n_rand;
  bit         sb;
  logic [7:0] rb;

  initial begin
    rst_n = 1'b0; rx = 1'b1; clr = 1'b0; baud_tick = 1'b0; rd_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // idle line after reset
    push(1'b1, 200);
    play_all();
    check("idle_ready", rx_ready, 0);
    check("idle_busy", rx_busy, 0);
    check("idle_data", rx_data, 8'h00);

    // 0x5A, completion exactly STOP_OFS ticks after detection, then read
    exp_q.delete();
    push(1'b1, 4);
    s = next_idx();
    push_frame(8'h5A, 1'b1);
    push(1'b1, 12);
    set_rd(s + STOP_OFS + 4);
    play_to(s + STOP_OFS - 1);
    check("ready_before_152", rx_ready, 0);
    play_to(s + STOP_OFS);
    check("ready_at_152", rx_ready, 1);
    check("data_5a", rx_data, 8'h5A);
    check("ferr_5a", rx_ferr, 0);
    play_all();
    check("ready_after_rd", rx_ready, 0);
    check("data_held_5a", rx_data, 8'h5A);
    check("model_q_5a", (exp_q.size() == 1 && exp_q[0] == 8'h5A), 1);

    // short low glitch is a false start, then 0xA5
    exp_q.delete();
    push(1'b1, 5);
    g = next_idx();
    push(1'b0, 4);
    push(1'b1, 20);
    play_to(g + HALF - 1);
    check("glitch_busy_before_mid", rx_busy, 1);
    play_to(g + HALF);
    check("glitch_busy_at_mid", rx_busy, 0);
    check("glitch_ready", rx_ready, 0);
    s = next_idx();
    push_frame(8'hA5, 1'b1);
    push(1'b1, 10);
    set_rd(s + STOP_OFS + 5);
    play_to(s + STOP_OFS);
    check("data_a5", rx_data, 8'hA5);
    check("ready_a5", rx_ready, 1);
    play_all();
    check("model_q_a5", (exp_q.size() == 1 && exp_q[0] == 8'hA5), 1);

    // 0x3C with low stop bit, line held low, then released
    exp_q.delete();
    s = next_idx();
    push_frame(8'h3C, 1'b0);
    push(1'b0, 40);
    push(1'b1, 30);
    play_to(s + STOP_OFS);
    check("data_3c", rx_data, 8'h3C);
    check("ferr_3c", rx_ferr, 1);
    play_to(s + STOP_OFS + 40);
    check("break_busy", rx_busy, 1);
    check("break_state", dbg_state, 3'd4);
    play_all();
    check("break_exit_busy", rx_busy, 0);
    check("break_no_ovr", rx_ovr, 0);
    check("model_q_3c", (exp_q.size() == 1 && exp_q[0] == 8'h3C), 1);
    g = next_idx();
    push(1'b1, 3);
    set_rd(g);
    play_all();
    check("ferr_cleared", rx_ferr, 0);

    // back-to-back 0x11, 0x22 without a read: overrun
    exp_q.delete();
    push_frame(8'h11, 1'b1);
    push_frame(8'h22, 1'b1);
    push(1'b1, 10);
    play_all();
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", rx_ovr, 1);
    check("model_q_ovr", (exp_q.size() == 1 && exp_q[0] == 8'h11), 1);
    g = next_idx();
    push(1'b1, 3);
    set_rd(g);
    play_all();
    check("ovr_cleared", rx_ovr, 0);

    // same pair, read coincident with the second stop tick
    exp_q.delete();
    push_frame(8'h11, 1'b1);
    s2 = next_idx();
    push_frame(8'h22, 1'b1);
    push(1'b1, 10);
    set_rd(s2 + STOP_OFS);
    play_all();
    check("coinc_data", rx_data, 8'h22);
    check("coinc_ready", rx_ready, 1);
    check("coinc_ovr", rx_ovr, 0);
    check("model_q_coinc", (exp_q.size() == 2 && exp_q[1] == 8'h22), 1);
    g = next_idx();
    push(1'b1, 3);
    set_rd(g);
    play_all();

    // clr at data bit 4 of 0xFF abandons it; 0x81 follows
    exp_q.delete();
    s = next_idx();
    push_frame(8'hFF, 1'b1);
    push(1'b1, 6);
    set_clr(s + HALF + OS * 5);
    play_to(s + HALF + OS * 5);
    check("clr_busy", rx_busy, 0);
    check("clr_ready", rx_ready, 0);
    s2 = next_idx();
    push_frame(8'h81, 1'b1);
    push(1'b1, 10);
    play_all();
    check("data_81", rx_data, 8'h81);
    check("model_q_81", (exp_q.size() == 1 && exp_q[0] == 8'h81), 1);
    g = next_idx();
    push(1'b1, 3);
    set_rd(g);
    play_all();

    // random traffic: frames, glitches, breaks, random reads and clears
    n_rand = 0;
    for (int f = 0; f < 25; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        push(1'b0, $urandom_range(1, 7));
        push(1'b1, $urandom_range(9, 20));
      end else begin
        rb = 8'($urandom_range(0, 255));
        sb = (kind != 1);
        push_frame(rb, sb);
        if (!sb) push(1'b0, $urandom_range(0, 30));
        push(1'b1, $urandom_range(sb ? 0 : 1, 20));
      end
    end
    for (int i = 0; i < line_q.size(); i++) begin
      rd_q[i]  = ($urandom_range(0, 29) == 0);
      clr_q[i] = ($urandom_range(0, 799) == 0);
    end
    push(1'b1, 20);
    play_all();

    // asynchronous reset in the middle of a frame
    s = next_idx();
    push_frame(8'h77, 1'b1);
    s2 = next_idx();
    push_frame(8'h99, 1'b1);
    play_to(s2 + 50);
    rst_n = 1'b0; baud_tick = 1'b0; rd_en = 1'b0; clr = 1'b0; rx = 1'b1;
    model_reset();
    line_q.delete(); rd_q.delete(); clr_q.delete();
    #1;
    check("rst_data", rx_data, 8'h00);
    check("rst_ready", rx_ready, 0);
    check("rst_busy", rx_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, 20);
    play_all();
    check("post_rst_busy", rx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
